// File: rtl/counter_sweep_ctrl.sv
// Purpose: loads a seed into an up/down counter, sweeps it to full and/or empty, and checks its feedback every cycle.
// Latency: the seed is loaded 1 cycle after start and checking begins 2 cycles after start; an up sweep from s completes at cycle 3+(2^N-1-s).
// Backpressure: none; start is accepted only in IDLE, abort returns to IDLE from any busy state, and a mismatch sets a sticky error without stalling.
module counter_sweep_ctrl #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_abort,
    input  logic [1:0]   i_mode,
    input  logic [N-1:0] i_seed,
    input  logic [N-1:0] i_result,
    input  logic         i_full,
    input  logic         i_empty,
    output logic         o_en,
    output logic         o_load,
    output logic         o_dir,
    output logic [N-1:0] o_data,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_UP,
        S_DOWN,
        S_DONE
    } state_t;

    localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
    localparam logic [N-1:0] ZERO     = {N{1'b0}};
    localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

    state_t       state;
    logic [N-1:0] exp_cnt;   // shadow of the count the counter should be showing
    logic [N-1:0] seed_q;
    logic [1:0]   mode_q;
    logic         phase_q;   // set once the second leg of a two-leg sweep has begun
    logic         error_q;

    logic at_top;
    logic at_bot;
    logic chk_state;
    logic mismatch;

    assign at_top    = (exp_cnt == ALL_ONES);
    assign at_bot    = (exp_cnt == ZERO);
    // Feedback is only meaningful once the load has landed, so LOAD and IDLE are never checked.
    assign chk_state = (state == S_UP) || (state == S_DOWN) || (state == S_DONE);
    assign mismatch  = chk_state &&
                       ((i_result != exp_cnt) || (i_full != at_top) || (i_empty != at_bot));

    // Sweep sequencer: state, shadow count, captured command and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            exp_cnt <= ZERO;
            seed_q  <= ZERO;
            mode_q  <= 2'd0;
            phase_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            if (mismatch) begin
                error_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        seed_q  <= i_seed;
                        mode_q  <= i_mode;
                        phase_q <= 1'b0;
                        error_q <= 1'b0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    exp_cnt <= seed_q;
                    // Modes 0 and 2 start upward, 1 and 3 start downward.
                    state   <= mode_q[0] ? S_DOWN : S_UP;
                end
                S_UP: begin
                    if (!at_top) begin
                        exp_cnt <= exp_cnt + ONE;
                    end else if ((mode_q == 2'd2) && !phase_q) begin
                        phase_q <= 1'b1;
                        state   <= S_DOWN;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DOWN: begin
                    if (!at_bot) begin
                        exp_cnt <= exp_cnt - ONE;
                    end else if ((mode_q == 2'd3) && !phase_q) begin
                        phase_q <= 1'b1;
                        state   <= S_UP;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
            // Abort overrides any busy-state transition; the error flag is left alone.
            if (i_abort && (state != S_IDLE)) begin
                state <= S_IDLE;
            end
        end
    end

    // Outputs decode only registered state, so nothing from the inputs reaches them combinationally.
    assign o_busy  = (state != S_IDLE);
    assign o_load  = (state == S_LOAD);
    assign o_en    = (state == S_LOAD) ||
                     ((state == S_UP) && !at_top) ||
                     ((state == S_DOWN) && !at_bot);
    assign o_dir   = (state == S_UP);
    assign o_done  = (state == S_DONE);
    assign o_data  = (state == S_LOAD) ? seed_q : ZERO;
    assign o_error = error_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Purpose: drives counter_sweep_ctrl against a behavioural counter and compares every cycle with a per-cycle expected trace.
// Latency: the trace is built from seed and mode arithmetic, one entry per clock cycle, starting at the cycle that carries start.
// Backpressure: none; faults and aborts are injected at chosen trace indices.
module tb_counter_sweep_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_abort;
    logic [1:0] i_mode;
    logic [7:0] i_seed;
    logic [7:0] i_result;
    logic       i_full;
    logic       i_empty;
    logic       o_en;
    logic       o_load;
    logic       o_dir;
    logic [7:0] o_data;
    logic       o_busy;
    logic       o_done;
    logic       o_error;

    // Behavioural counter with fault injection on its feedback.
    logic [7:0] cnt = 8'd0;
    logic       ov_res_en  = 1'b0;
    logic [7:0] ov_res_val = 8'd0;
    logic       flip_full  = 1'b0;
    logic       flip_empty = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    logic model_err = 1'b0;

    typedef struct {
        logic       en;
        logic       load;
        logic       dir;
        logic       busy;
        logic       done;
        logic       chk;
        logic [7:0] val;
    } ent_t;

    ent_t q[$];

    counter_sweep_ctrl #(.N(8)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_mode   (i_mode),
        .i_seed   (i_seed),
        .i_result (i_result),
        .i_full   (i_full),
        .i_empty  (i_empty),
        .o_en     (o_en),
        .o_load   (o_load),
        .o_dir    (o_dir),
        .o_data   (o_data),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_error  (o_error)
    );

    always #5 i_clk = ~i_clk;

    assign i_result = ov_res_en ? ov_res_val : cnt;
    assign i_full   = (cnt == 8'hFF) ^ flip_full;
    assign i_empty  = (cnt == 8'h00) ^ flip_empty;

    // Counter: load wins over count when enabled.
    always @(posedge i_clk) begin
        if (o_en === 1'b1) begin
            cnt <= (o_load === 1'b1) ? o_data : ((o_dir === 1'b1) ? cnt + 8'd1 : cnt - 8'd1);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp_v, $time);
        end
    endtask

    task automatic push(input logic en, input logic load, input logic dir, input logic busy,
                        input logic done, input logic chk, input logic [7:0] val);
        ent_t e;
        e.en = en; e.load = load; e.dir = dir; e.busy = busy;
        e.done = done; e.chk = chk; e.val = val;
        q.push_back(e);
    endtask

    // Expected cycle-by-cycle trace: IDLE(start), LOAD, one or two sweep legs, DONE, IDLE.
    task automatic build(input logic [1:0] mode, input logic [7:0] seed);
        int  v;
        int  legs;
        bit  up;
        q.delete();
        push(0, 0, 0, 0, 0, 0, 8'h00);
        push(1, 1, 0, 1, 0, 0, 8'h00);
        v    = int'(seed);
        legs = (mode >= 2'd2) ? 2 : 1;
        for (int ph = 0; ph < legs; ph++) begin
            up = ((mode == 2'd0) || (mode == 2'd2)) ^ (ph == 1);
            if (up) begin
                while (v != 255) begin
                    push(1, 0, 1, 1, 0, 1, 8'(v));
                    v++;
                end
                push(0, 0, 1, 1, 0, 1, 8'hFF);
            end else begin
                while (v != 0) begin
                    push(1, 0, 0, 1, 0, 1, 8'(v));
                    v--;
                end
                push(0, 0, 0, 1, 0, 1, 8'h00);
            end
        end
        push(0, 0, 0, 1, 1, 1, 8'(v));
        push(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic run(input logic [1:0] mode, input logic [7:0] seed, input int abort_at,
                       input int fault_at, input int ftype, input logic [7:0] fval,
                       input bit start_in_done);
        logic flag;
        int   ab;
        build(mode, seed);
        ab = abort_at;
        // Aborting in DONE or IDLE is not exercised here; treat it as no abort.
        if (ab >= q.size() - 2) ab = 0;
        if (ab > 0) begin
            while (q.size() > ab + 1) void'(q.pop_back());
            push(0, 0, 0, 0, 0, 0, 8'h00);
        end
        push(0, 0, 0, 0, 0, 0, 8'h00);
        flag = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            i_start    = (i == 0) || (start_in_done && q[i].done);
            i_mode     = (i == 0) ? mode : 2'($urandom);
            i_seed     = (i == 0) ? seed : 8'($urandom);
            i_abort    = (ab > 0 && i == ab) || (!q[i].busy && ($urandom_range(0, 1) == 1));
            ov_res_en  = (i == fault_at) && (ftype == 0);
            ov_res_val = fval;
            flip_full  = (i == fault_at) && (ftype == 1);
            flip_empty = (i == fault_at) && (ftype == 2);
            @(negedge i_clk);
            check_val("busy", o_busy, q[i].busy);
            check_val("done", o_done, q[i].done);
            check_val("en",   o_en,   q[i].en);
            check_val("load", o_load, q[i].load);
            check_val("dir",  o_dir,  q[i].dir);
            check_val("error", o_error, (i == 0) ? model_err : flag);
            if (q[i].load) check_val("data", o_data, seed);
            if (i == fault_at && q[i].chk) begin
                if (ftype != 0 || fval != q[i].val) flag = 1'b1;
            end
            @(posedge i_clk);
            #1;
        end
        model_err  = flag;
        i_start    = 1'b0;
        i_abort    = 1'b0;
        ov_res_en  = 1'b0;
        flip_full  = 1'b0;
        flip_empty = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_en"},    o_en,    1'b0);
        check_val({tag, "_load"},  o_load,  1'b0);
        check_val({tag, "_dir"},   o_dir,   1'b0);
        check_val({tag, "_data"},  o_data,  8'h00);
        check_val({tag, "_busy"},  o_busy,  1'b0);
        check_val({tag, "_done"},  o_done,  1'b0);
        check_val({tag, "_error"}, o_error, 1'b0);
    endtask

    // Reset held two cycles in the middle of an up sweep that has already flagged an error.
    task automatic reset_midsweep();
        i_start = 1'b1; i_mode = 2'd0; i_seed = 8'h10;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        flip_full = 1'b1;
        @(posedge i_clk); #1;
        flip_full = 1'b0;
        @(negedge i_clk);
        check_val("mid_busy",  o_busy,  1'b1);
        check_val("mid_error", o_error, 1'b1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("rst_mid");
        model_err = 1'b0;
        @(posedge i_clk); #1;
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_mode = 2'd0; i_seed = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk); #1;

        run(2'd0, 8'hFA, 0, -1, 0, 8'h00, 1'b1);
        run(2'd2, 8'h00, 0, -1, 0, 8'h00, 1'b0);
        run(2'd1, 8'h00, 0, -1, 0, 8'h00, 1'b0);
        run(2'd0, 8'h00, 0, 7, 0, 8'h00, 1'b0);
        run(2'd0, 8'hF0, 0, -1, 0, 8'h00, 1'b0);
        run(2'd3, 8'h80, 10, -1, 0, 8'h00, 1'b0);
        run(2'd3, 8'h05, 0, 9, 1, 8'h00, 1'b1);
        run(2'd1, 8'hFF, 0, 3, 2, 8'h00, 1'b0);
        reset_midsweep();
        run(2'd0, 8'hFF, 0, -1, 0, 8'h00, 1'b0);

        for (int r = 0; r < 24; r++) begin
            logic [1:0] m;
            logic [7:0] s;
            int         ab;
            int         fa;
            m = 2'($urandom);
            case ($urandom_range(0, 2))
                0:       s = 8'($urandom_range(0, 12));
                1:       s = 8'($urandom_range(243, 255));
                default: s = 8'($urandom);
            endcase
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            fa = ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : -1;
            run(m, s, ab, fa, $urandom_range(0, 2), 8'($urandom), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
